// File: rtl/einstein_kbd_pkg.sv
// Shared definitions for the Einstein keyboard matrix: key kinds, matrix
// geometry and the PS/2 set-2 scancode translation table.
package einstein_kbd_pkg;

    localparam int ROW_W    = 3;
    localparam int COL_W    = 3;
    localparam int NUM_ROWS = 1 << ROW_W;
    localparam int NUM_COLS = 1 << COL_W;

    typedef enum logic [2:0] {
        KIND_MATRIX = 3'd0,
        KIND_LSHIFT = 3'd1,
        KIND_RSHIFT = 3'd2,
        KIND_CTRL   = 3'd3,
        KIND_GRAPH  = 3'd4
    } kind_e;

    typedef struct packed {
        logic             hit;
        kind_e            kind;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } xlat_entry_t;

    typedef struct packed {
        logic lshift;
        logic rshift;
        logic ctrl;
        logic graph;
    } mods_t;

    function automatic xlat_entry_t key_at(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col);
        xlat_entry_t e;
        e.hit  = 1'b1;
        e.kind = KIND_MATRIX;
        e.row  = row;
        e.col  = col;
        return e;
    endfunction

    function automatic xlat_entry_t modifier(input kind_e kind);
        xlat_entry_t e;
        e.hit  = 1'b1;
        e.kind = kind;
        e.row  = '0;
        e.col  = '0;
        return e;
    endfunction

    // {extended, scancode} -> matrix position or modifier; anything not listed misses.
    function automatic xlat_entry_t xlat_lookup(input logic ext, input logic [7:0] code);
        xlat_entry_t e;
        e.hit  = 1'b0;
        e.kind = KIND_MATRIX;
        e.row  = '0;
        e.col  = '0;
        case ({ext, code})
            // row 0: digits 1-8
            9'h016: e = key_at(3'd0, 3'd0);
            9'h01E: e = key_at(3'd0, 3'd1);
            9'h026: e = key_at(3'd0, 3'd2);
            9'h025: e = key_at(3'd0, 3'd3);
            9'h02E: e = key_at(3'd0, 3'd4);
            9'h036: e = key_at(3'd0, 3'd5);
            9'h03D: e = key_at(3'd0, 3'd6);
            9'h03E: e = key_at(3'd0, 3'd7);
            // row 1: A S D F G H J K
            9'h01C: e = key_at(3'd1, 3'd0);
            9'h01B: e = key_at(3'd1, 3'd1);
            9'h023: e = key_at(3'd1, 3'd2);
            9'h02B: e = key_at(3'd1, 3'd3);
            9'h034: e = key_at(3'd1, 3'd4);
            9'h033: e = key_at(3'd1, 3'd5);
            9'h03B: e = key_at(3'd1, 3'd6);
            9'h042: e = key_at(3'd1, 3'd7);
            // row 2: Q W E R T Y U I
            9'h015: e = key_at(3'd2, 3'd0);
            9'h01D: e = key_at(3'd2, 3'd1);
            9'h024: e = key_at(3'd2, 3'd2);
            9'h02D: e = key_at(3'd2, 3'd3);
            9'h02C: e = key_at(3'd2, 3'd4);
            9'h035: e = key_at(3'd2, 3'd5);
            9'h03C: e = key_at(3'd2, 3'd6);
            9'h043: e = key_at(3'd2, 3'd7);
            // row 3: Z X C V B N M ,
            9'h01A: e = key_at(3'd3, 3'd0);
            9'h022: e = key_at(3'd3, 3'd1);
            9'h021: e = key_at(3'd3, 3'd2);
            9'h02A: e = key_at(3'd3, 3'd3);
            9'h032: e = key_at(3'd3, 3'd4);
            9'h031: e = key_at(3'd3, 3'd5);
            9'h03A: e = key_at(3'd3, 3'd6);
            9'h041: e = key_at(3'd3, 3'd7);
            // row 4: 9 0 - = O P L ;
            9'h046: e = key_at(3'd4, 3'd0);
            9'h045: e = key_at(3'd4, 3'd1);
            9'h04E: e = key_at(3'd4, 3'd2);
            9'h055: e = key_at(3'd4, 3'd3);
            9'h044: e = key_at(3'd4, 3'd4);
            9'h04D: e = key_at(3'd4, 3'd5);
            9'h04B: e = key_at(3'd4, 3'd6);
            9'h04C: e = key_at(3'd4, 3'd7);
            // row 5: . / ' [ ] \ ` Enter
            9'h049: e = key_at(3'd5, 3'd0);
            9'h04A: e = key_at(3'd5, 3'd1);
            9'h052: e = key_at(3'd5, 3'd2);
            9'h054: e = key_at(3'd5, 3'd3);
            9'h05B: e = key_at(3'd5, 3'd4);
            9'h05D: e = key_at(3'd5, 3'd5);
            9'h00E: e = key_at(3'd5, 3'd6);
            9'h05A: e = key_at(3'd5, 3'd7);
            // row 6: Backspace Tab Esc Up Down Left Right F1
            9'h066: e = key_at(3'd6, 3'd0);
            9'h00D: e = key_at(3'd6, 3'd1);
            9'h076: e = key_at(3'd6, 3'd2);
            9'h175: e = key_at(3'd6, 3'd3);
            9'h172: e = key_at(3'd6, 3'd4);
            9'h16B: e = key_at(3'd6, 3'd5);
            9'h174: e = key_at(3'd6, 3'd6);
            9'h005: e = key_at(3'd6, 3'd7);
            // row 7: Space CapsLock F2-F7
            9'h029: e = key_at(3'd7, 3'd0);
            9'h058: e = key_at(3'd7, 3'd1);
            9'h006: e = key_at(3'd7, 3'd2);
            9'h004: e = key_at(3'd7, 3'd3);
            9'h00C: e = key_at(3'd7, 3'd4);
            9'h003: e = key_at(3'd7, 3'd5);
            9'h00B: e = key_at(3'd7, 3'd6);
            9'h083: e = key_at(3'd7, 3'd7);
            // modifiers: both Ctrl keys share CTRL, both Alt keys share GRAPH
            9'h012: e = modifier(KIND_LSHIFT);
            9'h059: e = modifier(KIND_RSHIFT);
            9'h014: e = modifier(KIND_CTRL);
            9'h114: e = modifier(KIND_CTRL);
            9'h011: e = modifier(KIND_GRAPH);
            9'h111: e = modifier(KIND_GRAPH);
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/einstein_kbd_matrix_xlat.sv
// Front end of the keyboard pipeline: stage 0 spots a toggle on ps2_key[10]
// and latches the event, stage 1 registers the table lookup result.
module einstein_kbd_xlat
    import einstein_kbd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        s1_valid_o,
    output logic        s1_make_o,
    output xlat_entry_t s1_entry_o
);

    logic        toggle_q;
    logic        s0_valid_q;
    logic        s0_make_q;
    logic        s0_ext_q;
    logic [7:0]  s0_code_q;
    logic        s1_valid_q;
    logic        s1_make_q;
    xlat_entry_t s1_entry_q;

    logic        new_event;

    assign new_event = ps2_key[10] ^ toggle_q;

    // Toggle detect, event latch and registered lookup, one event per cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // History starts at 0 so a high toggle bit at release counts as one event.
            toggle_q   <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_make_q  <= 1'b0;
            s0_ext_q   <= 1'b0;
            s0_code_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_make_q  <= 1'b0;
            s1_entry_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous
            // cycle's value of the stage before it, independent of statement order.
            toggle_q   <= ps2_key[10];
            s0_valid_q <= new_event;
            if (new_event) begin
                s0_make_q <= ps2_key[9];
                s0_ext_q  <= ps2_key[8];
                s0_code_q <= ps2_key[7:0];
            end
            s1_valid_q <= s0_valid_q;
            s1_make_q  <= s0_make_q;
            s1_entry_q <= xlat_lookup(s0_ext_q, s0_code_q);
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign s1_make_o  = s1_make_q;
    assign s1_entry_o = s1_entry_q;

endmodule

// File: rtl/einstein_kbd_matrix.sv
// Einstein keyboard matrix emulation: PS/2 key events update a 64-bit key
// matrix plus modifier bits, scanned by the PSG as active-low rows/columns.
module einstein_kbd_matrix
    import einstein_kbd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        clear_all,
    input  logic [7:0]  kb_row,
    output logic [7:0]  kb_col,
    output logic        kb_shift,
    output logic        kb_ctrl,
    output logic        kb_graph,
    output logic        kb_event
);

    logic        s1_valid;
    logic        s1_make;
    xlat_entry_t s1_entry;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix_q, matrix_d;
    mods_t                             mods_q, mods_d;
    logic [NUM_COLS-1:0]               col_hit;
    logic [7:0]                        kb_col_q;
    logic                              kb_event_q;
    logic                              changed;

    einstein_kbd_xlat u_xlat (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .s1_valid_o (s1_valid),
        .s1_make_o  (s1_make),
        .s1_entry_o (s1_entry)
    );

    // Stage 2 next state: clear_all overrides any write landing in the same cycle.
    always_comb begin
        // NOTE: start from the held state so every path assigns every bit and
        // no latch is inferred.
        matrix_d = matrix_q;
        mods_d   = mods_q;
        if (clear_all) begin
            matrix_d = '0;
            mods_d   = '0;
        end else if (s1_valid && s1_entry.hit) begin
            case (s1_entry.kind)
                KIND_MATRIX: matrix_d[s1_entry.row][s1_entry.col] = s1_make;
                KIND_LSHIFT: mods_d.lshift = s1_make;
                KIND_RSHIFT: mods_d.rshift = s1_make;
                KIND_CTRL:   mods_d.ctrl   = s1_make;
                KIND_GRAPH:  mods_d.graph  = s1_make;
                default: ;
            endcase
        end
    end

    assign changed = (matrix_d != matrix_q) || (mods_d != mods_q);

    // Column sense from the next state so a write shows on kb_col at the same edge.
    always_comb begin
        col_hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!kb_row[r]) col_hit = col_hit | matrix_d[r];
        end
    end

    // Key state, registered column sense and change pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the matrix is plain flops rather than a RAM, so it is
            // reset together with the rest of the state.
            matrix_q   <= '0;
            mods_q     <= '0;
            kb_col_q   <= 8'hFF;
            kb_event_q <= 1'b0;
        end else begin
            matrix_q   <= matrix_d;
            mods_q     <= mods_d;
            kb_col_q   <= ~col_hit;
            kb_event_q <= changed;
        end
    end

    assign kb_col   = kb_col_q;
    assign kb_event = kb_event_q;
    assign kb_shift = ~(mods_q.lshift | mods_q.rshift);
    assign kb_ctrl  = ~mods_q.ctrl;
    assign kb_graph = ~mods_q.graph;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Directed bench for einstein_kbd_matrix with hand-computed expectations.
module tb_einstein_kbd_matrix;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clear_all;
    logic [7:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_shift;
    logic        kb_ctrl;
    logic        kb_graph;
    logic        kb_event;

    logic        tog;
    int          total = 0;
    int          bad   = 0;

    einstein_kbd_matrix dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .clear_all (clear_all),
        .kb_row    (kb_row),
        .kb_col    (kb_col),
        .kb_shift  (kb_shift),
        .kb_ctrl   (kb_ctrl),
        .kb_graph  (kb_graph),
        .kb_event  (kb_event)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic make, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, make, ext, code};
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        tog       = 1'b0;
        ps2_key   = '0;
        clear_all = 1'b0;
        kb_row    = 8'hFF;
        repeat (3) tick();
        check("rst_col",   kb_col,   8'hFF);
        check("rst_shift", kb_shift, 1);
        check("rst_ctrl",  kb_ctrl,  1);
        check("rst_graph", kb_graph, 1);
        check("rst_event", kb_event, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // make A, row 1 selected: visible exactly 3 edges after the toggle
        kb_row = 8'hFD;
        tick();
        send(1, 0, 8'h1C);
        tick();
        tick();
        check("a_early", kb_col, 8'hFF);
        tick();
        check("a_make",     kb_col,   8'hFE);
        check("a_make_ev",  kb_event, 1);
        tick();
        check("a_ev_once",  kb_event, 0);
        check("a_hold",     kb_col,   8'hFE);
        send(0, 0, 8'h1C);
        repeat (3) tick();
        check("a_break",    kb_col,   8'hFF);
        check("a_break_ev", kb_event, 1);

        // A and Space held, rows 1 and 7 selected together
        send(1, 0, 8'h1C);
        tick();
        send(1, 0, 8'h29);
        repeat (3) tick();
        kb_row = 8'h7D;
        tick();
        check("a_sp_col", kb_col, 8'hFE);
        kb_row = 8'hFF;
        check("row_latency", kb_col, 8'hFE);
        tick();
        check("row_none", kb_col, 8'hFF);

        // repeated make of a held key changes nothing
        send(1, 0, 8'h1C);
        repeat (3) tick();
        check("rep_make_ev", kb_event, 0);
        kb_row = 8'hFD;
        tick();
        check("rep_make_col", kb_col, 8'hFE);

        // S joins A in row 1
        send(1, 0, 8'h1B);
        repeat (3) tick();
        check("a_s_col", kb_col, 8'hFC);
        send(0, 0, 8'h1C);
        tick();
        send(0, 0, 8'h1B);
        tick();
        send(0, 0, 8'h29);
        repeat (3) tick();
        kb_row = 8'h00;
        tick();
        check("all_up", kb_col, 8'hFF);

        // shifts on consecutive cycles
        send(1, 0, 8'h12);
        tick();
        send(1, 0, 8'h59);
        tick();
        send(0, 0, 8'h12);
        tick();
        check("sh_ls",      kb_shift, 0);
        check("sh_ls_ev",   kb_event, 1);
        tick();
        check("sh_both",    kb_shift, 0);
        check("sh_both_ev", kb_event, 1);
        tick();
        check("sh_rs_only", kb_shift, 0);
        check("sh_rel_ev",  kb_event, 1);
        tick();
        check("sh_idle_ev", kb_event, 0);
        send(0, 0, 8'h59);
        repeat (3) tick();
        check("sh_none", kb_shift, 1);

        // ctrl and both Alt keys
        send(1, 0, 8'h14);
        repeat (3) tick();
        check("ctrl_make", kb_ctrl, 0);
        send(0, 0, 8'h14);
        repeat (3) tick();
        check("ctrl_break", kb_ctrl, 1);
        send(1, 1, 8'h11);
        repeat (3) tick();
        check("ralt_make", kb_graph, 0);
        send(0, 1, 8'h11);
        repeat (3) tick();
        check("ralt_break", kb_graph, 1);
        send(1, 0, 8'h11);
        repeat (3) tick();
        check("lalt_make", kb_graph, 0);
        send(0, 0, 8'h11);
        repeat (3) tick();
        check("lalt_break", kb_graph, 1);

        // unmapped 0x75 vs cursor up E0 0x75
        kb_row = 8'hBF;
        send(1, 0, 8'h75);
        repeat (3) tick();
        check("unmap_ev", kb_event, 0);
        tick();
        check("unmap_ev2", kb_event, 0);
        check("unmap_col", kb_col,   8'hFF);
        send(1, 1, 8'h75);
        repeat (3) tick();
        check("up_col", kb_col,   8'hF7);
        check("up_ev",  kb_event, 1);
        send(0, 1, 8'h75);
        repeat (3) tick();
        check("up_break", kb_col, 8'hFF);

        // clear_all colliding with a stage-2 write, next event still lands
        send(1, 0, 8'h29);
        repeat (3) tick();
        kb_row = 8'h00;
        send(1, 0, 8'h1B);
        tick();
        send(1, 0, 8'h1C);
        tick();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("clr_col", kb_col,   8'hFF);
        check("clr_ev",  kb_event, 1);
        tick();
        check("clr_after_col", kb_col,   8'hFE);
        check("clr_after_ev",  kb_event, 1);
        kb_row = 8'h7F;
        tick();
        check("clr_space_gone", kb_col, 8'hFF);
        kb_row = 8'hFD;
        tick();
        check("clr_s_gone", kb_col, 8'hFE);
        send(0, 0, 8'h1C);
        repeat (3) tick();

        // reset with two events in flight
        send(1, 0, 8'h14);
        tick();
        send(1, 0, 8'h1C);
        repeat (3) tick();
        check("pre_rst_ctrl", kb_ctrl, 0);
        send(1, 0, 8'h1B);
        tick();
        send(1, 0, 8'h29);
        tick();
        reset_n = 1'b0;
        tog     = 1'b0;
        ps2_key = '0;
        tick();
        check("mid_rst_col",   kb_col,   8'hFF);
        check("mid_rst_ctrl",  kb_ctrl,  1);
        check("mid_rst_event", kb_event, 0);
        reset_n = 1'b1;
        kb_row  = 8'h00;
        repeat (5) tick();
        check("post_rst_col",  kb_col,   8'hFF);
        check("post_rst_ev",   kb_event, 0);
        check("post_rst_ctrl", kb_ctrl,  1);

        // toggle bit high at reset release counts as one event
        reset_n = 1'b0;
        tick();
        tog     = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        kb_row  = 8'hFD;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("rel_early", kb_col, 8'hFF);
        tick();
        check("rel_col", kb_col,   8'hFE);
        check("rel_ev",  kb_event, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
